regfile_write_scheduler: RTL and testbench

//  Shares the register file's single write port between two producers: ALU writeback (A) and load/IO return (M).

---
 rtl/regfile_pkg.sv | 26 ++
 rtl/wr_hold_slot.sv | 38 +++
 rtl/regfile_write_scheduler.sv | 117 +++++++++++
 tb/tb_regfile_write_scheduler.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared widths and types for the register-file write scheduler.
// No logic; no latency; no backpressure.
// Imported by the slot, the top and the bench.
package regfile_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int NREG   = 16;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } rf_wr_t;

    typedef enum logic {
        SRC_A = 1'b0,
        SRC_M = 1'b1
    } rf_src_e;

    typedef enum logic [1:0] {
        AGE_NONE    = 2'd0,
        AGE_A_OLDER = 2'd1,
        AGE_M_OLDER = 2'd2
    } age_e;

endpackage

// File: rtl/wr_hold_slot.sv
// One-entry write holding slot; contents are visible the cycle after an accept.
// Ready while empty, or while being drained so a granted slot refills in the same cycle.
// Held data is never altered until it is drained.
module wr_hold_slot
    import regfile_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   i_vld,
    output logic   o_rdy,
    input  rf_wr_t i_dat,
    input  logic   i_drain,
    output logic   o_load,
    output logic   o_full,
    output rf_wr_t o_dat
);

    logic   r_full;
    rf_wr_t r_dat;

    assign o_rdy  = !r_full || i_drain;
    assign o_load = i_vld && o_rdy;
    assign o_full = r_full;
    assign o_dat  = r_dat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full <= 1'b0;
            r_dat  <= '0;
        end else if (o_load) begin
            r_full <= 1'b1;
            r_dat  <= i_dat;
        end else if (i_drain) begin
            r_full <= 1'b0;
        end
    end

endmodule

// File: rtl/regfile_write_scheduler.sv
// Arbitrates ALU (A) and load (M) writebacks onto the single register-file write port.
// A held write drives the port combinationally one cycle after its accept; one write per cycle.
// Each source stalls only while its slot is full and not granted; busy flags held writes.
module regfile_write_scheduler
    import regfile_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_data,
    input  logic              m_valid,
    output logic              m_ready,
    input  logic [ADDR_W-1:0] m_addr,
    input  logic [DATA_W-1:0] m_data,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_wa,
    output logic [DATA_W-1:0] rf_wd,
    output logic              rf_src,
    output logic [NREG-1:0]   busy
);

    logic    w_a_full, w_m_full;
    logic    w_a_load, w_m_load;
    rf_wr_t  w_a_dat, w_m_dat, w_gnt_dat;
    logic    w_gnt_a, w_gnt_m;
    logic    w_both, w_same;
    logic    w_a_nfull, w_m_nfull;
    logic [NREG-1:0] w_busy;
    rf_src_e r_rr;
    age_e    r_age;

    wr_hold_slot u_slot_a (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_vld   (a_valid),
        .o_rdy   (a_ready),
        .i_dat   ({a_addr, a_data}),
        .i_drain (w_gnt_a),
        .o_load  (w_a_load),
        .o_full  (w_a_full),
        .o_dat   (w_a_dat)
    );

    wr_hold_slot u_slot_m (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_vld   (m_valid),
        .o_rdy   (m_ready),
        .i_dat   ({m_addr, m_data}),
        .i_drain (w_gnt_m),
        .o_load  (w_m_load),
        .o_full  (w_m_full),
        .o_dat   (w_m_dat)
    );

    assign w_both = w_a_full && w_m_full;
    assign w_same = (w_a_dat.addr == w_m_dat.addr);

    // Same-address writes follow age so the later value lands last; otherwise round-robin.
    always_comb begin
        w_gnt_a = 1'b0;
        w_gnt_m = 1'b0;
        if (w_both) begin
            if (w_same) begin
                if (r_age == AGE_M_OLDER) w_gnt_m = 1'b1;
                else                      w_gnt_a = 1'b1;
            end else if (r_rr == SRC_A) begin
                w_gnt_a = 1'b1;
            end else begin
                w_gnt_m = 1'b1;
            end
        end else if (w_a_full) begin
            w_gnt_a = 1'b1;
        end else if (w_m_full) begin
            w_gnt_m = 1'b1;
        end
    end

    assign w_gnt_dat = w_gnt_m ? w_m_dat : (w_gnt_a ? w_a_dat : '0);
    assign rf_we     = (w_gnt_a || w_gnt_m) && (w_gnt_dat.addr != '0);
    assign rf_wa     = w_gnt_dat.addr;
    assign rf_wd     = w_gnt_dat.data;
    assign rf_src    = w_gnt_m ? SRC_M : SRC_A;

    always_comb begin
        w_busy = '0;
        if (w_a_full) w_busy[w_a_dat.addr] = 1'b1;
        if (w_m_full) w_busy[w_m_dat.addr] = 1'b1;
        w_busy[0] = 1'b0;
    end
    assign busy = w_busy;

    assign w_a_nfull = w_a_load || (w_a_full && !w_gnt_a);
    assign w_m_nfull = w_m_load || (w_m_full && !w_gnt_m);

    // The entry that stays put while the other slot loads becomes the older one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr  <= SRC_A;
            r_age <= AGE_NONE;
        end else begin
            if (w_both && !w_same)
                r_rr <= w_gnt_a ? SRC_M : SRC_A;
            if (!w_a_nfull || !w_m_nfull)
                r_age <= AGE_NONE;
            else if (w_a_load && w_m_load)
                r_age <= AGE_NONE;
            else if (w_m_load)
                r_age <= AGE_A_OLDER;
            else if (w_a_load)
                r_age <= AGE_M_OLDER;
        end
    end

endmodule

// File: tb/tb_regfile_write_scheduler.sv
// Scoreboard bench for regfile_write_scheduler: accepted writes are queued per source
// and popped when the write port fires; directed cases cover reset, WAW and r0.
module tb_regfile_write_scheduler;
    import regfile_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              a_valid, m_valid;
    logic              a_ready, m_ready;
    logic [ADDR_W-1:0] a_addr, m_addr;
    logic [DATA_W-1:0] a_data, m_data;
    logic              rf_we, rf_src;
    logic [ADDR_W-1:0] rf_wa;
    logic [DATA_W-1:0] rf_wd;
    logic [NREG-1:0]   busy;

    int     n_vec = 0;
    int     n_err = 0;
    rf_wr_t exp_a[$];
    rf_wr_t exp_m[$];
    logic   glog[$];
    logic   glog_en = 1'b0;
    logic [DATA_W-1:0] shadow [NREG];
    logic   a_acc, m_acc, a_rdy_s, m_rdy_s;

    always #5 clk = ~clk;

    regfile_write_scheduler dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .a_valid (a_valid),
        .a_ready (a_ready),
        .a_addr  (a_addr),
        .a_data  (a_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_addr  (m_addr),
        .m_data  (m_data),
        .rf_we   (rf_we),
        .rf_wa   (rf_wa),
        .rf_wd   (rf_wd),
        .rf_src  (rf_src),
        .busy    (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Accepts are decided by the ready/valid seen before the edge; r0 writes never reach the port.
    task automatic tick();
        @(negedge clk);
        a_rdy_s = a_ready;
        m_rdy_s = m_ready;
        a_acc   = a_valid && a_ready;
        m_acc   = m_valid && m_ready;
        if (a_acc && a_addr != '0) exp_a.push_back({a_addr, a_data});
        if (m_acc && m_addr != '0) exp_m.push_back({m_addr, m_data});
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((busy != '0 || rf_we) && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk(tag, 32'(n < 40), 1);
    endtask

    always @(negedge clk) begin : mon
        rf_wr_t e;
        if (rst_n && rf_we) begin
            shadow[rf_wa] = rf_wd;
            if (glog_en) glog.push_back(rf_src);
            if (rf_src) begin
                if (exp_m.size() == 0) chk("sb_m_unexpected", 32'({rf_wa, rf_wd}), 0);
                else begin
                    e = exp_m.pop_front();
                    chk("sb_m", 32'({rf_wa, rf_wd}), 32'(e));
                end
            end else begin
                if (exp_a.size() == 0) chk("sb_a_unexpected", 32'({rf_wa, rf_wd}), 0);
                else begin
                    e = exp_a.pop_front();
                    chk("sb_a", 32'({rf_wa, rf_wd}), 32'(e));
                end
            end
        end
    end

    task automatic chk_idle(input string tag);
        chk({tag, "_we"},   32'(rf_we), 0);
        chk({tag, "_wa"},   32'(rf_wa), 0);
        chk({tag, "_wd"},   32'(rf_wd), 0);
        chk({tag, "_src"},  32'(rf_src), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_ardy"}, 32'(a_ready), 1);
        chk({tag, "_mrdy"}, 32'(m_ready), 1);
    endtask

    initial begin
        for (int i = 0; i < NREG; i++) shadow[i] = '0;
        rst_n = 1'b0;
        a_valid = 1'b0; a_addr = '0; a_data = '0;
        m_valid = 1'b0; m_addr = '0; m_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk_idle("rst");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // First write after release: visible one cycle after accept
        a_valid = 1'b1; a_addr = 4'd3; a_data = 8'h5A;
        tick();
        a_valid = 1'b0;
        chk("t1_we", 32'(rf_we), 1);
        chk("t1_wa", 32'(rf_wa), 3);
        chk("t1_busy3", 32'(busy[3]), 1);
        tick();

        // Single source A r5=0x3C
        a_valid = 1'b1; a_addr = 4'd5; a_data = 8'h3C;
        tick();
        a_valid = 1'b0;
        chk("t2_busy5", 32'(busy[5]), 1);
        chk("t2_we", 32'(rf_we), 1);
        chk("t2_wa", 32'(rf_wa), 5);
        chk("t2_wd", 32'(rf_wd), 'h3C);
        chk("t2_src", 32'(rf_src), 0);
        tick();
        chk("t2_busy5_clr", 32'(busy[5]), 0);
        chk("t2_idle_we", 32'(rf_we), 0);
        chk("t2_idle_wd", 32'(rf_wd), 0);

        // Contended streaming: grants alternate A,M and readies toggle
        glog.delete();
        glog_en = 1'b1;
        a_valid = 1'b1; a_addr = 4'd1; a_data = 8'h40;
        m_valid = 1'b1; m_addr = 4'd2; m_data = 8'h80;
        for (int i = 0; i < 16; i++) begin
            tick();
            if (i > 0) begin
                chk("t3_ardy", 32'(a_rdy_s), 32'(i % 2 == 1));
                chk("t3_mrdy", 32'(m_rdy_s), 32'(i % 2 == 0));
            end
            if (a_acc) a_data = a_data + 8'd1;
            if (m_acc) m_data = m_data + 8'd1;
        end
        a_valid = 1'b0; m_valid = 1'b0;
        wait_idle("t3_drain");
        glog_en = 1'b0;
        chk("t3_ngrants", 32'(glog.size()), 17);
        for (int k = 0; k < glog.size(); k++) chk("t3_order", 32'(glog[k]), 32'(k % 2));
        chk("t3_sb_a_left", 32'(exp_a.size()), 0);
        chk("t3_sb_m_left", 32'(exp_m.size()), 0);

        // Reset mid-burst discards held writes
        a_valid = 1'b1; a_addr = 4'd6; a_data = 8'h61;
        m_valid = 1'b1; m_addr = 4'd8; m_data = 8'h81;
        repeat (3) tick();
        #2;
        rst_n = 1'b0;
        a_valid = 1'b0; m_valid = 1'b0;
        #1;
        exp_a.delete();
        exp_m.delete();
        chk_idle("mb");
        @(negedge clk) rst_n = 1'b1;
        repeat (3) tick();
        chk("mb_post_we", 32'(rf_we), 0);
        chk("mb_post_busy", 32'(busy), 0);

        // Staggered WAW: M r4 waits behind A r9, then A r4 arrives; M must go first
        a_valid = 1'b1; a_addr = 4'd9; a_data = 8'h99;
        m_valid = 1'b1; m_addr = 4'd4; m_data = 8'h44;
        tick();
        m_valid = 1'b0;
        chk("t5_c1_src", 32'(rf_src), 0);
        chk("t5_c1_wa", 32'(rf_wa), 9);
        chk("t5_c1_mrdy", 32'(m_ready), 0);
        a_addr = 4'd4; a_data = 8'hA4;
        tick();
        chk("t5_a_acc", 32'(a_acc), 1);
        a_valid = 1'b0;
        chk("t5_c2_src", 32'(rf_src), 1);
        chk("t5_c2_wd", 32'(rf_wd), 'h44);
        chk("t5_c2_busy4", 32'(busy[4]), 1);
        tick();
        chk("t5_c3_src", 32'(rf_src), 0);
        chk("t5_c3_wd", 32'(rf_wd), 'hA4);
        chk("t5_c3_busy4", 32'(busy[4]), 1);
        tick();
        chk("t5_busy4_clr", 32'(busy[4]), 0);
        chk("t5_r4", 32'(shadow[4]), 'hA4);

        // Same-edge WAW: A first, M value is final
        a_valid = 1'b1; a_addr = 4'd7; a_data = 8'h11;
        m_valid = 1'b1; m_addr = 4'd7; m_data = 8'h22;
        tick();
        a_valid = 1'b0; m_valid = 1'b0;
        chk("t4_c1_src", 32'(rf_src), 0);
        chk("t4_c1_wd", 32'(rf_wd), 'h11);
        chk("t4_c1_busy7", 32'(busy[7]), 1);
        tick();
        chk("t4_c2_src", 32'(rf_src), 1);
        chk("t4_c2_wd", 32'(rf_wd), 'h22);
        chk("t4_c2_busy7", 32'(busy[7]), 1);
        tick();
        chk("t4_busy7_clr", 32'(busy[7]), 0);
        chk("t4_r7", 32'(shadow[7]), 'h22);

        // r0: accepted, grant cycle consumed, no write, never busy
        a_valid = 1'b1; a_addr = 4'd0; a_data = 8'hFF;
        m_valid = 1'b1; m_addr = 4'd0; m_data = 8'hEE;
        tick();
        chk("t6_a_acc", 32'(a_acc), 1);
        chk("t6_m_acc", 32'(m_acc), 1);
        a_valid = 1'b0; m_valid = 1'b0;
        chk("t6_c1_we", 32'(rf_we), 0);
        chk("t6_c1_src", 32'(rf_src), 0);
        chk("t6_c1_wd", 32'(rf_wd), 'hFF);
        chk("t6_c1_busy", 32'(busy), 0);
        tick();
        chk("t6_c2_we", 32'(rf_we), 0);
        chk("t6_c2_src", 32'(rf_src), 1);
        chk("t6_c2_wd", 32'(rf_wd), 'hEE);
        chk("t6_c2_busy", 32'(busy), 0);
        tick();
        chk("t6_idle_wd", 32'(rf_wd), 0);
        chk("t6_idle_mrdy", 32'(m_ready), 1);

        chk("end_sb_a_left", 32'(exp_a.size()), 0);
        chk("end_sb_m_left", 32'(exp_m.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
